// File: rtl/pipeif_fetch.sv
// pipeif_fetch: instruction-fetch stage with variable-latency imem, IF/ID register and delayed-branch redirect.
module pipeif_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid,
    output logic [31:0] pc
);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t state, state_next;
    logic [31:0] hbuf, redir_pc, pc4, target, npc;
    logic redir, honour, advance, park, bubble;
    always_comb begin
        pc4        = pc + 32'd4;
        honour     = wpcir && dvalid && (pcsource != 2'b00);
        target     = pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? da : jpc;
        advance    = wpcir && (state == HOLD || imem_ack);
        npc        = honour ? target : redir ? redir_pc : pc4;
        park       = state == FETCH && imem_ack && !wpcir;
        bubble     = state == FETCH && !imem_ack && wpcir;
        state_next = advance ? FETCH : park ? HOLD : state;
        imem_req   = state == FETCH;
        imem_addr  = pc;
    end
    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= '0;
            inst     <= '0;
            dpc4     <= '0;
            dvalid   <= 1'b0;
            redir    <= 1'b0;
            redir_pc <= '0;
            hbuf     <= '0;
        end else if (advance) begin
            inst   <= state == HOLD ? hbuf : imem_rdata;
            dpc4   <= pc4;
            dvalid <= 1'b1;
            pc     <= npc;
            redir  <= 1'b0;
        end else begin
            if (park) hbuf <= imem_rdata;
            if (bubble) begin
                inst   <= '0;
                dvalid <= 1'b0;
            end
            // a branch resolved while its delay slot is still in flight is remembered for the next fetch
            if (honour) begin
                redir    <= 1'b1;
                redir_pc <= target;
            end
        end
    end
endmodule

// File: tb/tb_pipeif_fetch.sv
// tb_pipeif_fetch: directed stimulus; expected IF/ID and fetch-port values are queued and checked by a separate monitor.
module tb_pipeif_fetch;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wpcir = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, da = '0, jpc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst, dpc4, pc;
    logic        dvalid;

    pipeif_fetch dut (
        .clock(clock), .reset(reset), .wpcir(wpcir), .pcsource(pcsource),
        .bpc(bpc), .da(da), .jpc(jpc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .dpc4(dpc4), .dvalid(dvalid), .pc(pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] inst;
        logic [31:0] dpc4;
        logic        dvalid;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            tests++;
            if (e.cyc != cyc ||
                {inst, dpc4, dvalid, imem_req, imem_addr} != {e.inst, e.dpc4, e.dvalid, e.req, e.addr}) begin
                fails++;
                $display("FAIL %s: got inst=%h dpc4=%h dvalid=%b req=%b addr=%h, expected inst=%h dpc4=%h dvalid=%b req=%b addr=%h",
                         e.name, inst, dpc4, dvalid, imem_req, imem_addr, e.inst, e.dpc4, e.dvalid, e.req, e.addr);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic w, input logic [1:0] ps,
                        input logic ack, input logic [31:0] rd,
                        input logic [31:0] x_inst, input logic [31:0] x_dpc4, input logic x_dv,
                        input logic x_req, input logic [31:0] x_addr);
        exp_t x;
        reset = rst; wpcir = w; pcsource = ps; imem_ack = ack; imem_rdata = rd;
        @(posedge clock);
        #1;
        x.cyc = cyc; x.name = name; x.inst = x_inst; x.dpc4 = x_dpc4;
        x.dvalid = x_dv; x.req = x_req; x.addr = x_addr;
        exp_q.push_back(x);
    endtask

    initial begin
        // reset ignores a concurrent ack
        step("reset",      1, 1, 2'b00, 1, 32'hDEAD, 0, 0, 0, 1, 0);
        // zero-wait streaming
        step("zw0",        0, 1, 2'b00, 1, 32'h11, 32'h11, 4,  1, 1, 4);
        step("zw1",        0, 1, 2'b00, 1, 32'h12, 32'h12, 8,  1, 1, 8);
        step("zw2",        0, 1, 2'b00, 1, 32'h13, 32'h13, 12, 1, 1, 12);
        step("zw3",        0, 1, 2'b00, 1, 32'h14, 32'h14, 16, 1, 1, 16);
        // late ack on addr 4: two bubbles
        step("reset2",     1, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        step("la_w0",      0, 1, 2'b00, 1, 32'h21, 32'h21, 4, 1, 1, 4);
        step("la_bub1",    0, 1, 2'b00, 0, 0, 0, 4, 0, 1, 4);
        step("la_bub2",    0, 1, 2'b00, 0, 0, 0, 4, 0, 1, 4);
        step("la_w4",      0, 1, 2'b00, 1, 32'h22, 32'h22, 8, 1, 1, 8);
        // ack while ID stalled: park in HOLD, then release
        step("hold1",      0, 0, 2'b00, 1, 32'h33, 32'h22, 8, 1, 0, 8);
        step("hold2",      0, 0, 2'b00, 0, 0, 32'h22, 8, 1, 0, 8);
        step("hold3",      0, 0, 2'b00, 0, 0, 32'h22, 8, 1, 0, 8);
        step("hold_rel",   0, 1, 2'b00, 0, 0, 32'h33, 12, 1, 1, 12);
        step("hold_next",  0, 1, 2'b00, 1, 32'h34, 32'h34, 16, 1, 1, 16);
        // branch with zero-wait delay slot
        step("br_a",       0, 1, 2'b00, 1, 32'h40, 32'h40, 20,    1, 1, 20);
        step("br_b",       0, 1, 2'b00, 1, 32'h41, 32'h41, 24,    1, 1, 24);
        step("br_c",       0, 1, 2'b00, 1, 32'h42, 32'h42, 28,    1, 1, 28);
        step("br_insn",    0, 1, 2'b00, 1, 32'h43, 32'h43, 32'h20, 1, 1, 32'h20);
        bpc = 32'h100;
        step("br_slot",    0, 1, 2'b01, 1, 32'h44, 32'h44, 32'h24, 1, 1, 32'h100);
        step("br_target",  0, 1, 2'b00, 1, 32'h50, 32'h50, 32'h104, 1, 1, 32'h104);
        // branch resolved while delay slot waits three cycles
        step("rd_insn",    0, 1, 2'b00, 1, 32'h60, 32'h60, 32'h108, 1, 1, 32'h108);
        bpc = 32'h200;
        step("rd_bub1",    0, 1, 2'b01, 0, 0, 0, 32'h108, 0, 1, 32'h108);
        bpc = 32'h999;
        step("rd_bub2",    0, 1, 2'b01, 0, 0, 0, 32'h108, 0, 1, 32'h108);
        step("rd_bub3",    0, 1, 2'b01, 0, 0, 0, 32'h108, 0, 1, 32'h108);
        step("rd_slot",    0, 1, 2'b00, 1, 32'h61, 32'h61, 32'h10C, 1, 1, 32'h200);
        step("rd_clear",   0, 1, 2'b00, 1, 32'h70, 32'h70, 32'h204, 1, 1, 32'h204);
        // jr and jump targets
        da = 32'h300; jpc = 32'h400;
        step("jr",         0, 1, 2'b10, 1, 32'h71, 32'h71, 32'h208, 1, 1, 32'h300);
        step("jmp",        0, 1, 2'b11, 1, 32'h72, 32'h72, 32'h304, 1, 1, 32'h400);
        step("jmp_next",   0, 1, 2'b00, 1, 32'h73, 32'h73, 32'h404, 1, 1, 32'h404);
        // pcsource ignored while wpcir=0
        step("ps_ignored", 0, 0, 2'b01, 0, 0, 32'h73, 32'h404, 1, 1, 32'h404);
        step("ps_noredir", 0, 1, 2'b00, 1, 32'h74, 32'h74, 32'h408, 1, 1, 32'h408);
        // PC wrap-around
        jpc = 32'hFFFF_FFFC;
        step("wrap_jmp",   0, 1, 2'b11, 1, 32'h75, 32'h75, 32'h40C, 1, 1, 32'hFFFF_FFFC);
        step("wrap",       0, 1, 2'b00, 1, 32'h76, 32'h76, 32'h0, 1, 1, 32'h0);
        // reset mid-wait with a late ack
        step("rw_a",       0, 1, 2'b00, 1, 32'h77, 32'h77, 4, 1, 1, 4);
        step("rw_wait",    0, 1, 2'b00, 0, 0, 0, 4, 0, 1, 4);
        step("rw_reset",   1, 1, 2'b00, 1, 32'hBAD, 0, 0, 0, 1, 0);
        // reset during HOLD
        step("rh_a",       0, 1, 2'b00, 1, 32'h80, 32'h80, 4, 1, 1, 4);
        step("rh_hold",    0, 0, 2'b00, 1, 32'h81, 32'h80, 4, 1, 0, 4);
        step("rh_reset",   1, 1, 2'b00, 1, 32'hBAD, 0, 0, 0, 1, 0);
        step("rh_after",   0, 1, 2'b00, 1, 32'h90, 32'h90, 4, 1, 1, 4);
        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
